tick_gen_frac: RTL and testbench

Parametrised multi-channel timebase generator in the `clk_sys` domain, successor to the single-channel integer `mtime` tick divider. Each of `N_CHANNELS` channels divides `clk_sys` by a programmable integer-plus-fraction ratio and emits a one-cycle pulse plus an NRZ toggle per tick. The outputs feed the RISC-V platform timer, the audio sample clock-enable and the LCD frame timer. Configuration is via an APB slave. Channels support one-shot mode and simultaneous phase re-alignment.

---
 rtl/tick_gen_frac_pkg.sv | 52 +++++
 rtl/tick_gen_frac_channel.sv | 55 +++++
 rtl/tick_gen_frac.sv | 124 ++++++++++++
 tb/tb_tick_gen_frac.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_frac_pkg.sv
// Shared constants and APB decode helpers for the fractional
// multi-channel tick generator.
package tick_gen_frac_pkg;

  localparam logic [7:0] SYNC_OFF  = 8'h00;
  localparam logic [7:0] CTRL_BASE = 8'h10;
  localparam logic [7:0] DIV_BASE  = 8'h14;
  localparam int         CH_STRIDE = 8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_SYNC,
    REG_CTRL,
    REG_DIV
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [3:0] ch;
  } reg_dec_t;

  // INT=1, FRAC=0 packed into the DIV layout
  function automatic logic [31:0] div_reset(input int frac_w);
    return 32'd1 << frac_w;
  endfunction

  function automatic reg_dec_t reg_decode(
    input logic [7:0] addr,
    input int         n_ch
  );
    reg_dec_t   d;
    logic [7:0] off;
    d.kind = REG_NONE;
    d.ch   = '0;
    off    = addr - CTRL_BASE;
    if (addr[1:0] == 2'b00) begin
      if (addr == SYNC_OFF) begin
        d.kind = REG_SYNC;
      end else if (addr >= CTRL_BASE &&
                   int'(off) < n_ch * CH_STRIDE) begin
        d.ch   = off[6:3];
        d.kind = (off[2:0] == 3'(DIV_BASE - CTRL_BASE))
               ? REG_DIV : REG_CTRL;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/tick_gen_frac_channel.sv
// One timebase channel: reload counter, fraction accumulator,
// registered pulse and NRZ outputs.
module tick_gen_frac_channel
  import tick_gen_frac_pkg::*;
#(
  parameter int INT_W = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             sync,
  input  logic [INT_W-1:0] int_div,
  input  logic [AW-1:0]    frac_div,
  output logic             tick,
  output logic             tick_pulse,
  output logic             tick_nrz
);

  localparam logic [INT_W:0] ONE = (INT_W+1)'(1);

  logic [INT_W:0] ctr;
  logic [AW-1:0]  acc;
  logic [AW:0]    sum;
  logic [INT_W:0] reload;

  assign sum    = {1'b0, acc} + {1'b0, frac_div};
  assign reload = {1'b0, int_div};

  // A realign on this edge swallows the tick it would replace
  assign tick = en && !sync && (ctr == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr        <= '0;
      acc        <= '0;
      tick_pulse <= 1'b0;
      tick_nrz   <= 1'b0;
    end else begin
      tick_pulse <= tick;
      tick_nrz   <= tick_nrz ^ tick;
      if (start || sync) begin
        ctr <= reload;
        acc <= '0;
      end else if (tick) begin
        acc <= sum[AW-1:0];
        ctr <= reload + {{INT_W{1'b0}}, sum[AW]};
      end else if (en && ctr != '0) begin
        ctr <= ctr - ONE;
      end
    end
  end

endmodule

// File: rtl/tick_gen_frac.sv
// Multi-channel fractional tick generator with APB register
// file, one-shot support and simultaneous realignment.
module tick_gen_frac
  import tick_gen_frac_pkg::*;
#(
  parameter int N_CHANNELS = 4,
  parameter int INT_W      = 8,
  parameter int FRAC_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  apbs_psel,
  input  logic                  apbs_penable,
  input  logic                  apbs_pwrite,
  input  logic [19:0]           apbs_paddr,
  input  logic [31:0]           apbs_pwdata,
  output logic [31:0]           apbs_prdata,
  output logic                  apbs_pready,
  output logic                  apbs_pslverr,
  output logic [N_CHANNELS-1:0] tick_pulse,
  output logic [N_CHANNELS-1:0] tick_nrz
);

  localparam int N  = N_CHANNELS;
  localparam int DW = INT_W + FRAC_W;
  localparam int AW = (FRAC_W > 0) ? FRAC_W : 1;
  localparam logic [DW-1:0] DIV_RST = DW'(div_reset(FRAC_W));

  logic           wr;
  reg_dec_t       dec;
  logic [N-1:0]   en_q;
  logic [N-1:0]   os_q;
  logic [N-1:0]   tick;
  logic [N-1:0]   start;
  logic [N-1:0]   sync;
  logic [DW-1:0]  div_q    [N];
  logic [INT_W-1:0] int_div [N];
  logic [AW-1:0]  frac_div [N];
  logic           unused;

  assign dec          = reg_decode(apbs_paddr[7:0], N);
  assign wr           = apbs_psel & apbs_penable & apbs_pwrite;
  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = 1'b0;
  assign unused       = ^{apbs_paddr[19:8], apbs_pwdata};

  always_comb begin
    start = '0;
    sync  = '0;
    for (int i = 0; i < N; i++) begin
      start[i] = wr && dec.kind == REG_CTRL &&
                 dec.ch == 4'(i) &&
                 apbs_pwdata[CTRL_EN] && !en_q[i];
      sync[i]  = wr && dec.kind == REG_SYNC &&
                 apbs_pwdata[i] && en_q[i];
    end
  end

  // Software CTRL writes take priority over the one-shot clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      os_q <= '0;
      for (int i = 0; i < N; i++) div_q[i] <= DIV_RST;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr && dec.kind == REG_CTRL && dec.ch == 4'(i)) begin
          en_q[i] <= apbs_pwdata[CTRL_EN];
          os_q[i] <= apbs_pwdata[CTRL_ONESHOT];
        end else if (tick[i] && os_q[i]) begin
          en_q[i] <= 1'b0;
        end
        if (wr && dec.kind == REG_DIV && dec.ch == 4'(i)) begin
          div_q[i] <= apbs_pwdata[DW-1:0];
        end
      end
    end
  end

  always_comb begin
    apbs_prdata = '0;
    if (apbs_psel) begin
      unique case (1'b1)
        dec.kind == REG_CTRL: begin
          for (int i = 0; i < N; i++)
            if (dec.ch == 4'(i))
              apbs_prdata = {30'd0, os_q[i], en_q[i]};
        end
        dec.kind == REG_DIV: begin
          for (int i = 0; i < N; i++)
            if (dec.ch == 4'(i))
              apbs_prdata = 32'(div_q[i]);
        end
        default: apbs_prdata = '0;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    assign int_div[g] = div_q[g][FRAC_W +: INT_W];
    if (FRAC_W > 0) begin : g_frac
      assign frac_div[g] = div_q[g][AW-1:0];
    end else begin : g_nofrac
      assign frac_div[g] = '0;
    end

    tick_gen_frac_channel #(
      .INT_W (INT_W),
      .AW    (AW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en_q[g]),
      .start      (start[g]),
      .sync       (sync[g]),
      .int_div    (int_div[g]),
      .frac_div   (frac_div[g]),
      .tick       (tick[g]),
      .tick_pulse (tick_pulse[g]),
      .tick_nrz   (tick_nrz[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_frac.sv
// Directed self-checking bench for tick_gen_frac.
// Edge T is the commit edge of the starting write; j counts edges after T.
module tb_tick_gen_frac;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         psel = 1'b0;
  logic         penable = 1'b0;
  logic         pwrite = 1'b0;
  logic [19:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic [N-1:0] tick_pulse;
  logic [N-1:0] tick_nrz;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tick_gen_frac #(
    .N_CHANNELS (N),
    .INT_W      (8),
    .FRAC_W     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apbs_psel    (psel),
    .apbs_penable (penable),
    .apbs_pwrite  (pwrite),
    .apbs_paddr   (paddr),
    .apbs_pwdata  (pwdata),
    .apbs_prdata  (prdata),
    .apbs_pready  (pready),
    .apbs_pslverr (pslverr),
    .tick_pulse   (tick_pulse),
    .tick_nrz     (tick_nrz)
  );

  function automatic logic [7:0] a_ctrl(input int ch);
    return 8'(8'h10 + 8 * ch);
  endfunction

  function automatic logic [7:0] a_div(input int ch);
    return 8'(8'h14 + 8 * ch);
  endfunction

  // Returns 1 ns after the commit edge
  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {12'h0, a}; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = {12'h0, a};
    #1 d = prdata;
    psel = 1'b0;
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_run++;
    if (tick_pulse !== 4'h0 || tick_nrz !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_out: pulse=%h nrz=%h want 0/0", tick_pulse, tick_nrz);
    end
    for (int i = 0; i < N; i++) begin
      apb_rd(a_ctrl(i), d);
      n_run++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_ctrl%0d: got %h want 0", i, d);
      end
      apb_rd(a_div(i), d);
      n_run++;
      if (d !== 32'h10) begin
        n_fail++;
        $display("FAIL reset_div%0d: got %h want 10", i, d);
      end
    end
    apb_rd(8'h00, d);
    n_run++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL sync_read: got %h want 0", d);
    end
    apb_rd(8'h0C, d);
    n_run++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h want 0", d);
    end
    @(negedge clk);
    paddr = {12'h0, a_div(0)};
    #1;
    n_run++;
    if (prdata !== 32'h0 || pready !== 1'b1 || pslverr !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bus: prdata=%h rdy=%b err=%b want 0/1/0",
               prdata, pready, pslverr);
    end
  endtask

  task automatic test_int5();
    do_reset();
    apb_wr(a_div(0), 32'h50);
    apb_wr(a_ctrl(0), 32'h1);
    apb_wr(a_ctrl(0), 32'h1);
    for (int j = 3; j <= 16; j++) begin
      @(posedge clk); #1;
      n_run++;
      if (tick_pulse[0] !== (j % 5 == 0) ||
          tick_nrz[0] !== 1'((j / 5) % 2)) begin
        n_fail++;
        $display("FAIL int5 j=%0d: pulse=%b nrz=%b want %b/%b", j,
                 tick_pulse[0], tick_nrz[0], (j % 5 == 0), (j / 5) % 2);
      end
    end
  endtask

  task automatic test_int1();
    do_reset();
    apb_wr(a_ctrl(0), 32'h1);
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      n_run++;
      if (tick_pulse[0] !== 1'b1 || tick_nrz[0] !== 1'(j % 2)) begin
        n_fail++;
        $display("FAIL int1 j=%0d: pulse=%b nrz=%b want 1/%0d", j,
                 tick_pulse[0], tick_nrz[0], j % 2);
      end
    end
  endtask

  task automatic test_parked();
    logic [31:0] d;
    int cnt;
    do_reset();
    apb_wr(a_div(0), 32'h0);
    apb_wr(a_ctrl(0), 32'h1);
    cnt = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (tick_pulse[0] === 1'b1) cnt++;
    end
    n_run++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL parked_pulses: got %0d want 0", cnt);
    end
    apb_rd(a_ctrl(0), d);
    n_run++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL parked_ctrl: got %h want 1", d);
    end
  endtask

  task automatic test_frac();
    int cnt;
    int pos [5];
    int want [5];
    want = '{3, 6, 9, 12, 16};
    do_reset();
    apb_wr(a_div(1), 32'h34);
    apb_wr(a_ctrl(1), 32'h1);
    cnt = 0;
    for (int j = 1; j <= 400; j++) begin
      @(posedge clk); #1;
      if (tick_pulse[1] === 1'b1) begin
        if (cnt < 5) pos[cnt] = j;
        cnt++;
      end
    end
    n_run++;
    if (cnt != 123) begin
      n_fail++;
      $display("FAIL frac_count: got %0d want 123", cnt);
    end
    for (int k = 0; k < 5; k++) begin
      n_run++;
      if (cnt <= k || pos[k] != want[k]) begin
        n_fail++;
        $display("FAIL frac_pos%0d: got %0d want %0d", k,
                 (cnt > k) ? pos[k] : -1, want[k]);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    do_reset();
    apb_wr(a_div(2), 32'h40);
    apb_wr(a_ctrl(2), 32'h3);
    for (int j = 1; j <= 54; j++) begin
      @(posedge clk); #1;
      n_run++;
      if (tick_pulse[2] !== (j == 4)) begin
        n_fail++;
        $display("FAIL oneshot j=%0d: got %b want %b", j,
                 tick_pulse[2], (j == 4));
      end
    end
    apb_rd(a_ctrl(2), d);
    n_run++;
    if (d !== 32'h2 || tick_nrz[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_ctrl: ctrl=%h nrz=%b want 2/1", d, tick_nrz[2]);
    end
  endtask

  task automatic test_sync();
    logic [3:0] ep;
    logic [3:0] en;
    do_reset();
    apb_wr(a_div(0), 32'h70);
    apb_wr(a_div(1), 32'h70);
    apb_wr(a_ctrl(0), 32'h1);
    @(posedge clk);
    apb_wr(a_ctrl(1), 32'h1);
    apb_wr(8'h00, 32'h3);
    for (int j = 1; j <= 15; j++) begin
      @(posedge clk); #1;
      ep = (j == 7 || j == 14) ? 4'h3 : 4'h0;
      en = (j >= 7 && j < 14) ? 4'h3 : 4'h0;
      n_run++;
      if (tick_pulse !== ep || tick_nrz !== en) begin
        n_fail++;
        $display("FAIL sync j=%0d: pulse=%h nrz=%h want %h/%h", j,
                 tick_pulse, tick_nrz, ep, en);
      end
    end
  endtask

  task automatic test_div_change_reset();
    logic [31:0] d;
    do_reset();
    apb_wr(a_div(3), 32'h60);
    apb_wr(a_ctrl(3), 32'h1);
    apb_wr(a_div(3), 32'h20);
    for (int j = 3; j <= 10; j++) begin
      @(posedge clk); #1;
      n_run++;
      if (tick_pulse[3] !== (j == 6 || j == 8 || j == 10)) begin
        n_fail++;
        $display("FAIL divchg j=%0d: got %b want %b", j, tick_pulse[3],
                 (j == 6 || j == 8 || j == 10));
      end
    end
    n_run++;
    if (tick_nrz[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL divchg_nrz: got %b want 1", tick_nrz[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (tick_pulse !== 4'h0 || tick_nrz !== 4'h0) begin
      n_fail++;
      $display("FAIL async_rst: pulse=%h nrz=%h want 0/0", tick_pulse, tick_nrz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apb_rd(a_ctrl(3), d);
    n_run++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ctrl3: got %h want 0", d);
    end
    apb_rd(a_div(3), d);
    n_run++;
    if (d !== 32'h10) begin
      n_fail++;
      $display("FAIL rst_div3: got %h want 10", d);
    end
  endtask

  initial begin
    test_reset();
    test_int5();
    test_int1();
    test_parked();
    test_frac();
    test_oneshot();
    test_sync();
    test_div_change_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
